instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder_pkg.sv | 28 ++
 rtl/instr_encoder_pack.sv | 41 ++++
 rtl/instr_encoder.sv | 100 ++++++++++
 tb/tb_instr_encoder.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/instr_encoder_pkg.sv
// Shared types and constants for the RV32I ALU instruction encoder.
// Optional I-type support is enabled by defining ITYPE_EN.
package instr_encoder_pkg;

   localparam logic [6:0] OP_RTYPE = 7'b0110011;
   localparam logic [6:0] OP_ITYPE = 7'b0010011;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      FULL = 2'd2
   } state_t;

   typedef enum logic {
      KIND_R = 1'b0,
      KIND_I = 1'b1
   } kind_t;

endpackage

// File: rtl/instr_encoder_pack.sv
// Combinational RV32I ALU encoding and legality check.
// I-type encoding exists only when ITYPE_EN is defined; otherwise I-type is illegal.
module instr_pack
   import instr_encoder_pkg::*;
(
   input  kind_t       kind,
   input  logic [2:0]  funct3,
   input  logic        funct7b5,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [11:0] imm,
   output logic [31:0] instr,
   output logic        legal
);

   always_comb begin
      instr = '0;
      legal = 1'b0;
      if (kind == KIND_R) begin
         instr = {1'b0, funct7b5, 5'b0, rs2, rs1, funct3, rd, OP_RTYPE};
         // funct7b5 only means something for SUB and SRA
         legal = !funct7b5 || (funct3 == F3_ADD) || (funct3 == F3_SR);
      end else begin
`ifdef ITYPE_EN
         instr = {imm, rs1, funct3, rd, OP_ITYPE};
         case (funct3)
            F3_SLL:  legal = (imm[11:5] == 7'b0000000);
            F3_SR:   legal = (imm[11:5] == 7'b0000000) || (imm[11:5] == 7'b0100000);
            default: legal = 1'b1;
         endcase
`endif
      end
   end

`ifndef ITYPE_EN
   logic unused_imm;
   assign unused_imm = ^imm;
`endif

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: accepts ALU requests, emits encoded RV32I words with byte addresses.
// Holds FSM, address/count and output registers; I-type support via ITYPE_EN.
module instr_encoder
   import instr_encoder_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          DEPTH     = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_kind,
   input  logic [2:0]  funct3,
   input  logic        funct7b5,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [11:0] imm,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_addr,
   output logic        full,
   output logic        err
);

   localparam int CW = $clog2(DEPTH + 1);

   state_t          state, state_nxt;
   logic [31:0]     word;
   logic            legal;
   logic [CW-1:0]   count, count_nxt;
   logic            accept, fire;

   instr_pack u_pack (
      .kind     (kind_t'(in_kind)),
      .funct3   (funct3),
      .funct7b5 (funct7b5),
      .rd       (rd),
      .rs1      (rs1),
      .rs2      (rs2),
      .imm      (imm),
      .instr    (word),
      .legal    (legal)
   );

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == HOLD);
   assign full      = (state == FULL);
   assign accept    = in_valid && in_ready;
   assign fire      = out_valid && out_ready;
   assign count_nxt = count + CW'(1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (clear) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    if (accept && legal) state_nxt = HOLD;
            HOLD:    if (out_ready) state_nxt = (count_nxt == CW'(DEPTH)) ? FULL : IDLE;
            FULL:    state_nxt = FULL;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_instr <= '0;
         out_addr  <= BASE_ADDR;
         count     <= '0;
         err       <= 1'b0;
      end else begin
         err <= 1'b0;
         if (clear) begin
            out_addr <= BASE_ADDR;
            count    <= '0;
         end else begin
            if (accept) begin
               if (legal) out_instr <= word;
               else       err       <= 1'b1;
            end
            // address wraps naturally at 2^32
            if (fire) begin
               out_addr <= out_addr + 32'd4;
               count    <= count_nxt;
            end
         end
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized self-checking bench for instr_encoder against a behavioural model.
// Model follows ITYPE_EN the same way the build does.
module tb_instr_encoder;

   localparam logic [31:0] BASE  = 32'h0000_0000;
   localparam int          DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        clear = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        in_kind = 1'b0;
   logic [2:0]  funct3 = '0;
   logic        funct7b5 = 1'b0;
   logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
   logic [11:0] imm = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_instr;
   logic [31:0] out_addr;
   logic        full;
   logic        err;

   int n_chk = 0;
   int n_fail = 0;

   logic [31:0] m_addr;
   int          m_count;
   bit          m_full;
   logic [31:0] m_word;
   bit          last_legal;

   instr_encoder #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .clear(clear),
      .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
      .funct3(funct3), .funct7b5(funct7b5), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
      .out_addr(out_addr), .full(full), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic bit ref_legal(bit k, int f3, bit f7, int im);
      if (!k) return !(f7 && f3 != 0 && f3 != 5);
`ifdef ITYPE_EN
      if (f3 == 1) return (im / 32) == 0;
      if (f3 == 5) return ((im / 32) == 0) || ((im / 32) == 32);
      return 1'b1;
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [31:0] ref_word(bit k, int f3, bit f7, int d, int s1, int s2, int im);
      longint w;
      if (!k) w = f7 * (1 << 30) + s2 * (1 << 20) + s1 * (1 << 15) + f3 * (1 << 12) + d * 128 + 51;
      else    w = longint'(im) * (1 << 20) + s1 * (1 << 15) + f3 * (1 << 12) + d * 128 + 19;
      return w[31:0];
   endfunction

   task automatic model_reset();
      m_addr = BASE; m_count = 0; m_full = 0;
   endtask

   // assumes called at posedge+1 with the DUT idle
   task automatic send(input bit k, input int f3, input bit f7, input int d, input int s1,
                       input int s2, input int im);
      int guard = 0;
      while (!in_ready && guard < 20) begin
         @(posedge clk); #1; guard++;
      end
      if (!in_ready) begin
         chk("in_ready_wait", {31'b0, in_ready}, 32'd1);
         last_legal = 0;
         return;
      end
      in_kind = k; funct3 = 3'(f3); funct7b5 = f7; rd = 5'(d); rs1 = 5'(s1); rs2 = 5'(s2);
      imm = 12'(im); in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      last_legal = ref_legal(k, f3, f7, im);
      if (last_legal) begin
         m_word = ref_word(k, f3, f7, d, s1, s2, im);
         chk("emit_valid", {31'b0, out_valid}, 32'd1);
         chk("emit_instr", out_instr, m_word);
         chk("emit_addr", out_addr, m_addr);
         chk("emit_err", {31'b0, err}, 32'd0);
      end else begin
         chk("ill_err", {31'b0, err}, 32'd1);
         chk("ill_valid", {31'b0, out_valid}, 32'd0);
         @(posedge clk); #1;
         chk("ill_err_drop", {31'b0, err}, 32'd0);
         chk("ill_ready", {31'b0, in_ready}, 32'd1);
      end
   endtask

   task automatic drain(input int stall);
      for (int i = 0; i < stall; i++) begin
         @(posedge clk); #1;
         chk("hold_valid", {31'b0, out_valid}, 32'd1);
         chk("hold_instr", out_instr, m_word);
         chk("hold_addr", out_addr, m_addr);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      m_addr = m_addr + 32'd4; m_count++; m_full = (m_count == DEPTH);
      chk("drain_valid", {31'b0, out_valid}, 32'd0);
      chk("drain_full", {31'b0, full}, {31'b0, m_full});
      chk("drain_ready", {31'b0, in_ready}, {31'b0, !m_full});
      chk("drain_addr", out_addr, m_addr);
   endtask

   task automatic do_clear();
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      model_reset();
      chk("clr_addr", out_addr, BASE);
      chk("clr_full", {31'b0, full}, 32'd0);
      chk("clr_valid", {31'b0, out_valid}, 32'd0);
      chk("clr_ready", {31'b0, in_ready}, 32'd1);
   endtask

   initial begin
      model_reset();
      #12;
      chk("rst_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_instr", out_instr, 32'd0);
      chk("rst_addr", out_addr, BASE);
      chk("rst_full", {31'b0, full}, 32'd0);
      chk("rst_err", {31'b0, err}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;

      // ADD with 3 cycles of backpressure
      send(0, 0, 0, 3, 1, 2, 0);
      chk("add_const", out_instr, 32'h002081B3);
      drain(3);
      // SUB at next address
      send(0, 0, 1, 3, 1, 2, 0);
      chk("sub_const", out_instr, 32'h402081B3);
      chk("sub_addr", out_addr, BASE + 32'd4);
      drain(0);
      // ADDI -1 (illegal without I-type support)
      send(1, 0, 0, 5, 0, 0, 12'hFFF);
`ifdef ITYPE_EN
      chk("addi_const", out_instr, 32'hFFF00293);
      drain(1);
`endif
      // shift with bad imm[11:5]
      send(1, 5, 0, 1, 2, 0, 12'h0A3);
      // fill to DEPTH
      while (!m_full) begin
         send(0, $urandom_range(0, 7), 0, $urandom_range(0, 31), $urandom_range(0, 31),
              $urandom_range(0, 31), 0);
         drain(0);
      end
      in_valid = 1'b1;
      repeat (2) begin
         @(posedge clk); #1;
         chk("full_hold", {31'b0, full}, 32'd1);
         chk("full_ready", {31'b0, in_ready}, 32'd0);
         chk("full_valid", {31'b0, out_valid}, 32'd0);
      end
      in_valid = 1'b0;
      do_clear();

      // reset while a word is pending
      send(0, 4, 0, 7, 8, 9, 0);
      #3 reset = 1'b1;
      #1;
      chk("rsth_valid", {31'b0, out_valid}, 32'd0);
      chk("rsth_addr", out_addr, BASE);
      chk("rsth_instr", out_instr, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      model_reset();
      out_ready = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         chk("rsth_stale", {31'b0, out_valid}, 32'd0);
      end
      out_ready = 1'b0;

      // random traffic
      for (int it = 0; it < 250; it++) begin
         if (m_full) begin
            chk("rnd_full", {31'b0, full}, 32'd1);
            chk("rnd_full_rdy", {31'b0, in_ready}, 32'd0);
            do_clear();
         end else begin
            bit k = 1'($urandom_range(0, 1));
            int f3 = $urandom_range(0, 7);
            bit f7 = ($urandom_range(0, 3) == 0);
            int im;
            case ($urandom_range(0, 2))
               0: im = $urandom_range(0, 31);
               1: im = 32'h400 + $urandom_range(0, 31);
               default: im = $urandom_range(0, 4095);
            endcase
            send(k, f3, f7, $urandom_range(0, 31), $urandom_range(0, 31),
                 $urandom_range(0, 31), im);
            if (last_legal) begin
               if ($urandom_range(0, 9) == 0) do_clear();
               else drain($urandom_range(0, 2));
            end
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
